// File: rtl/multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock,
// fixed W-clock latency from operand accept to the done pulse.
module multiplier #(
  parameter int W = 6
) (
  input  logic           c,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   xM,
  input  logic [W-1:0]   yM,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] zM
);
  // state | meaning
  // IDLE  | waiting for start; operands latched on the accepting edge
  // RUN   | one shift-and-add iteration per clock, W iterations total
  // DONE  | product valid in zM, one-cycle done pulse
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int            CW   = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state_q, state_d;
  logic [2*W-1:0] mcand_q, mcand_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] z_q, z_d;
  logic [2*W-1:0] acc_sum;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_iter;

  always_ff @(posedge c) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      z_q      <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_iter = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The final iteration's add is folded straight into zM on the exit edge.
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    z_d      = z_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (state_q == IDLE && start) begin
      mcand_d  = {{W{1'b0}}, xM};
      mplier_d = yM;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (state_q == RUN) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last_iter) z_d = acc_sum;
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    zM   = z_q;
  end

endmodule

// File: tb/tb_multiplier.sv
// Directed bench for the shift-and-add multiplier; expected products queue up
// at stimulus time and are popped whenever done pulses.
module tb_multiplier;
  localparam int W = 6;

  logic           c = 1'b0;
  logic           rst, start;
  logic [W-1:0]   xM, yM;
  logic           busy, done;
  logic [2*W-1:0] zM;

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0;
  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] exp_z;
  logic [2*W-1:0] last_z = '0;

  multiplier #(.W(W)) dut (
    .c(c), .rst(rst), .start(start), .xM(xM), .yM(yM),
    .busy(busy), .done(done), .zM(zM)
  );

  always #5 c = ~c;
  always @(posedge c) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  always @(negedge c) begin
    if (rst === 1'b0 && done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        exp_z = sb.pop_front();
        check("zM_result", 32'(zM), 32'(exp_z));
        last_z = exp_z;
      end
    end
  end

  task automatic tick();
    @(negedge c);
    #1;
  endtask

  // Present operands with start for one accepting edge; returns cycle stamp of E0.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit push, output int e0);
    start = 1'b1; xM = x; yM = y;
    if (push) sb.push_back((2*W)'(x) * (2*W)'(y));
    @(posedge c);
    #1;
    e0 = cyc;
    start = 1'b0; xM = '0; yM = '0;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 4*W; i++) begin
      tick();
      if (done) begin
        at = cyc;
        break;
      end
      check("zM_hold", 32'(zM), 32'(last_z));
    end
    if (at < 0) check("done_timeout", 0, 1);
  endtask

  task automatic full_op(input logic [W-1:0] x, input logic [W-1:0] y);
    int e0, at;
    start_op(x, y, 1'b1, e0);
    wait_done(at);
    check("latency", 32'(at - e0), W);
    tick();
    check("busy_after", 32'(busy), 0);
    check("done_after", 32'(done), 0);
  endtask

  initial begin
    int e0, at, d0, d1, d2, busy_n, done_n, done_at;
    rst = 1'b1; start = 1'b0; xM = '0; yM = '0;
    repeat (2) @(posedge c);
    tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_zM", 32'(zM), 0);
    @(posedge c);
    #1 rst = 1'b0;

    // basic 5x7 with busy/done duration
    start_op(6'd5, 6'd7, 1'b1, e0);
    busy_n = 0; done_n = 0; done_at = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = cyc; end
    end
    check("basic_latency", 32'(done_at - e0), W);
    check("basic_busy_cycles", busy_n, W + 1);
    check("basic_done_cycles", done_n, 1);

    // extremes
    full_op(6'd63, 6'd63);
    full_op(6'd0, 6'd42);
    full_op(6'd1, 6'd63);

    // start while busy is ignored at E3 and in DONE
    d0 = done_cnt;
    start_op(6'd5, 6'd7, 1'b1, e0);
    repeat (2) @(posedge c);
    #1 start = 1'b1; xM = 6'd2; yM = 6'd2;
    @(posedge c);
    #1 start = 1'b0;
    repeat (3) @(posedge c);
    #1 start = 1'b1;
    @(posedge c);
    #1 start = 1'b0;
    tick();
    check("busy_ignore_idle", 32'(busy), 0);
    repeat (5) tick();
    check("busy_ignore_pulses", done_cnt - d0, 1);
    check("busy_ignore_sb_empty", sb.size(), 0);
    full_op(6'd2, 6'd2);

    // operands zeroed after accept (start_op clears them at E0+1)
    full_op(6'd9, 6'd9);

    // reset at E3 aborts
    start_op(6'd10, 6'd10, 1'b0, e0);
    repeat (2) @(posedge c);
    #1 rst = 1'b1;
    @(posedge c);
    #1 rst = 1'b0;
    last_z = '0;
    tick();
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_zM", 32'(zM), 0);
    d0 = done_cnt;
    repeat (10) tick();
    check("abort_no_pulse", done_cnt - d0, 0);
    full_op(6'd3, 6'd4);

    // back-to-back with start held high
    @(posedge c);
    #1 start = 1'b1; xM = 6'd6; yM = 6'd6;
    sb.push_back(12'd36);
    @(posedge c);
    #1 e0 = cyc; xM = 6'd7; yM = 6'd8;
    sb.push_back(12'd56);
    wait_done(d1);
    @(posedge c);
    @(posedge c);
    #1 start = 1'b0;
    wait_done(d2);
    check("b2b_first_latency", 32'(d1 - e0), W);
    check("b2b_spacing", 32'(d2 - d1), W + 2);
    tick();
    check("b2b_idle", 32'(busy), 0);
    check("b2b_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
